// File: rtl/interrupt_controller_pkg.sv
// Shared constants, state encoding and helpers for the interrupt controller.
package interrupt_controller_pkg;

    localparam int unsigned NUM_SRC    = 5;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned VEC_STRIDE = 8;

    localparam logic [ADDR_W-1:0] IF_ADDR  = 16'hFF0F;
    localparam logic [ADDR_W-1:0] IE_ADDR  = 16'hFFFF;
    localparam logic [ADDR_W-1:0] VEC_BASE = 16'h0040;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVING = 1'b1
    } ack_state_e;

    // Result of the priority search: whether anything is pending and which bit wins.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Lowest set bit wins; scan from the top so the lowest index is written last.
    function automatic prio_t lowest_set(input logic [NUM_SRC-1:0] v);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Dispatch address for source idx.
    function automatic logic [ADDR_W-1:0] vector_for(input logic [IDX_W-1:0] idx);
        return ADDR_W'(VEC_BASE + (ADDR_W'(idx) * ADDR_W'(VEC_STRIDE)));
    endfunction

endpackage

// File: rtl/interrupt_controller_edge_detect.sv
// Per-bit rising-edge detector; history only advances on enabled cycles.
module edge_detect #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_sig,
    output logic [WIDTH-1:0] o_rise_c
);

    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;

    // Next history value and gated edge output.
    always_comb begin
        hist_d   = hist_q;
        o_rise_c = '0;
        if (i_enable) begin
            hist_d   = i_sig;
            o_rise_c = i_sig & ~hist_q;
        end
    end

    // History register; cleared so lines high at reset release register one edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Five-source interrupt controller with memory-mapped IF/IE and vectored dispatch.
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Enable,
    input  logic [ADDR_W-1:0]  i_Address,
    input  logic               i_Address_Out,
    input  logic [DATA_W-1:0]  i_Bus,
    input  logic               i_Bus_Out,
    input  logic               i_Bus_In,
    input  logic               i_Handle_Interrupt,
    input  logic [NUM_SRC-1:0] i_Requests,
    output logic [DATA_W-1:0]  o_Bus,
    output logic [NUM_SRC-1:0] o_Interrupts,
    output logic [ADDR_W-1:0]  o_Vector,
    output logic               o_Vector_Valid
);

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [NUM_SRC-1:0] if_q, if_d;
    logic [DATA_W-1:0]  ie_q, ie_d;
    ack_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  vector_q, vector_d;
    logic               valid_q, valid_d;

    logic               sel_if_c;
    logic               sel_ie_c;
    logic [NUM_SRC-1:0] pending_c;
    logic [NUM_SRC-1:0] rise_c;
    logic [NUM_SRC-1:0] if_base_c;
    logic [NUM_SRC-1:0] ack_clr_c;
    prio_t              prio_c;

    edge_detect #(
        .WIDTH (NUM_SRC)
    ) u_edge_detect (
        .i_clk    (i_Clk),
        .i_rst_n  (i_Rst_n),
        .i_enable (i_Enable),
        .i_sig    (i_Requests),
        .o_rise_c (rise_c)
    );

    assign sel_if_c  = (addr_q == IF_ADDR);
    assign sel_ie_c  = (addr_q == IE_ADDR);
    assign pending_c = if_q & ie_q[NUM_SRC-1:0];
    assign prio_c    = lowest_set(pending_c);

    assign o_Interrupts   = pending_c;
    assign o_Vector       = vector_q;
    assign o_Vector_Valid = valid_q;

    // Read mux; zero when unselected so the CPU can OR it onto its bus.
    always_comb begin
        o_Bus = '0;
        if (i_Bus_In) begin
            if (sel_if_c) begin
                o_Bus = {3'b111, if_q};
            end else if (sel_ie_c) begin
                o_Bus = ie_q;
            end
        end
    end

    // Next-state: address latch, register writes, acknowledge FSM and IF update.
    always_comb begin
        addr_d    = addr_q;
        ie_d      = ie_q;
        state_d   = state_q;
        vector_d  = vector_q;
        valid_d   = valid_q;
        if_base_c = if_q;
        ack_clr_c = '0;

        if (i_Enable) begin
            if (i_Address_Out) begin
                addr_d = i_Address;
            end
            if (i_Bus_Out) begin
                if (sel_if_c) begin
                    if_base_c = i_Bus[NUM_SRC-1:0];
                end
                if (sel_ie_c) begin
                    ie_d = i_Bus;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_Handle_Interrupt) begin
                        state_d = ST_SERVING;
                        valid_d = 1'b1;
                        if (prio_c.valid) begin
                            vector_d  = vector_for(prio_c.idx);
                            ack_clr_c = {{(NUM_SRC-1){1'b0}}, 1'b1} << prio_c.idx;
                        end else begin
                            vector_d = '0;
                        end
                    end
                end
                ST_SERVING: begin
                    if (!i_Handle_Interrupt) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        // Write value, then acknowledge clear, then peripheral edges on top.
        if_d = (if_base_c & ~ack_clr_c) | rise_c;
    end

    // State registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            addr_q   <= '0;
            if_q     <= '0;
            ie_q     <= '0;
            state_q  <= ST_IDLE;
            vector_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            if_q     <= if_d;
            ie_q     <= ie_d;
            state_q  <= state_d;
            vector_q <= vector_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scoreboard bench for interrupt_controller.
module tb_interrupt_controller;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n;
    logic        i_Enable;
    logic [15:0] i_Address;
    logic        i_Address_Out;
    logic [7:0]  i_Bus;
    logic        i_Bus_Out;
    logic        i_Bus_In;
    logic        i_Handle_Interrupt;
    logic [4:0]  i_Requests;
    logic [7:0]  o_Bus;
    logic [4:0]  o_Interrupts;
    logic [15:0] o_Vector;
    logic        o_Vector_Valid;

    interrupt_controller dut (
        .i_Clk              (i_Clk),
        .i_Rst_n            (i_Rst_n),
        .i_Enable           (i_Enable),
        .i_Address          (i_Address),
        .i_Address_Out      (i_Address_Out),
        .i_Bus              (i_Bus),
        .i_Bus_Out          (i_Bus_Out),
        .i_Bus_In           (i_Bus_In),
        .i_Handle_Interrupt (i_Handle_Interrupt),
        .i_Requests         (i_Requests),
        .o_Bus              (o_Bus),
        .o_Interrupts       (o_Interrupts),
        .o_Vector           (o_Vector),
        .o_Vector_Valid     (o_Vector_Valid)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic expect_val(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
        i_Address_Out = 1'b1;
        i_Address     = a;
        tick();
        i_Address_Out = 1'b0;
        i_Bus_Out     = 1'b1;
        i_Bus         = d;
        tick();
        i_Bus_Out     = 1'b0;
    endtask

    task automatic read_reg(input logic [15:0] a, output logic [7:0] d);
        i_Address_Out = 1'b1;
        i_Address     = a;
        tick();
        i_Address_Out = 1'b0;
        i_Bus_In      = 1'b1;
        #1;
        d        = o_Bus;
        i_Bus_In = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] rd;

        i_Rst_n = 1'b0;
        i_Enable = 1'b1;
        i_Address = 16'hFF0F;
        i_Address_Out = 1'b1;
        i_Bus = 8'hFF;
        i_Bus_Out = 1'b1;
        i_Bus_In = 1'b1;
        i_Handle_Interrupt = 1'b0;
        i_Requests = 5'h00;

        // Reset: strobes active but everything must read zero.
        #12;
        expect_val("reset_o_bus", 16'h0000);        check(16'(o_Bus));
        expect_val("reset_interrupts", 16'h0000);   check(16'(o_Interrupts));
        expect_val("reset_vector", 16'h0000);       check(o_Vector);
        expect_val("reset_valid", 16'h0000);        check(16'(o_Vector_Valid));
        i_Address_Out = 1'b0;
        i_Bus_Out = 1'b0;
        i_Bus_In = 1'b0;
        i_Rst_n = 1'b1;

        // Timer request with IE=04.
        write_reg(16'hFFFF, 8'h04);
        i_Requests = 5'h04;
        tick();
        i_Requests = 5'h00;
        expect_val("timer_interrupts", 16'h0004);   check(16'(o_Interrupts));
        read_reg(16'hFF0F, rd);
        expect_val("timer_read_if", 16'h00E4);      check(16'(rd));
        read_reg(16'hFFFF, rd);
        expect_val("timer_read_ie", 16'h0004);      check(16'(rd));

        // Priority dispatch: IF=06, IE=1F -> source 1.
        write_reg(16'hFFFF, 8'h1F);
        write_reg(16'hFF0F, 8'h06);
        expect_val("prio_pending", 16'h0006);       check(16'(o_Interrupts));
        i_Handle_Interrupt = 1'b1;
        tick();
        expect_val("prio_vector", 16'h0048);        check(o_Vector);
        expect_val("prio_valid", 16'h0001);         check(16'(o_Vector_Valid));
        expect_val("prio_if_after", 16'h0004);      check(16'(o_Interrupts));
        tick();
        expect_val("serving_hold_vector", 16'h0048); check(o_Vector);
        expect_val("serving_ignore_ack", 16'h0004);  check(16'(o_Interrupts));
        i_Handle_Interrupt = 1'b0;
        tick();
        expect_val("release_valid", 16'h0000);      check(16'(o_Vector_Valid));
        expect_val("release_vector_hold", 16'h0048); check(o_Vector);

        // Edge beats a same-edge IF write of zero.
        write_reg(16'hFF0F, 8'h00);
        expect_val("cleared_if", 16'h0000);         check(16'(o_Interrupts));
        i_Address_Out = 1'b1;
        i_Address = 16'hFF0F;
        tick();
        i_Address_Out = 1'b0;
        i_Bus_Out = 1'b1;
        i_Bus = 8'h00;
        i_Requests = 5'h01;
        tick();
        i_Bus_Out = 1'b0;
        expect_val("edge_beats_write", 16'h0001);   check(16'(o_Interrupts));
        i_Requests = 5'h00;
        tick();

        // Edge beats the acknowledge clear of the same bit.
        i_Handle_Interrupt = 1'b1;
        i_Requests = 5'h01;
        tick();
        expect_val("edge_ack_vector", 16'h0040);    check(o_Vector);
        expect_val("edge_beats_clear", 16'h0001);   check(16'(o_Interrupts));
        i_Handle_Interrupt = 1'b0;
        i_Requests = 5'h00;
        tick();
        expect_val("edge_ack_release", 16'h0000);   check(16'(o_Vector_Valid));

        // Cancelled dispatch: IF pending but masked.
        write_reg(16'hFFFF, 8'h00);
        write_reg(16'hFF0F, 8'h02);
        expect_val("cancel_pending", 16'h0000);     check(16'(o_Interrupts));
        i_Handle_Interrupt = 1'b1;
        tick();
        expect_val("cancel_vector", 16'h0000);      check(o_Vector);
        expect_val("cancel_valid", 16'h0001);       check(16'(o_Vector_Valid));
        read_reg(16'hFF0F, rd);
        expect_val("cancel_if_kept", 16'h00E2);     check(16'(rd));
        i_Handle_Interrupt = 1'b0;
        tick();

        // Enable gating: edge and write while disabled are ignored.
        i_Enable = 1'b0;
        i_Requests = 5'h08;
        i_Bus_Out = 1'b1;
        i_Bus = 8'h1F;
        tick();
        tick();
        i_Bus_In = 1'b1;
        #1;
        expect_val("gated_if", 16'h00E2);           check(16'(o_Bus));
        i_Bus_In = 1'b0;
        i_Bus_Out = 1'b0;
        i_Enable = 1'b1;
        tick();
        read_reg(16'hFF0F, rd);
        expect_val("held_req_seen", 16'h00EA);      check(16'(rd));
        tick();
        read_reg(16'hFF0F, rd);
        expect_val("held_req_once", 16'h00EA);      check(16'(rd));

        // Reset mid-SERVING with IF=1F.
        i_Requests = 5'h00;
        write_reg(16'hFFFF, 8'h1F);
        i_Handle_Interrupt = 1'b1;
        tick();
        expect_val("pre_reset_vector", 16'h0048);   check(o_Vector);
        write_reg(16'hFF0F, 8'h1F);
        expect_val("pre_reset_if", 16'h001F);       check(16'(o_Interrupts));
        expect_val("pre_reset_valid", 16'h0001);    check(16'(o_Vector_Valid));
        i_Requests = 5'h01;
        #2;
        i_Rst_n = 1'b0;
        #1;
        expect_val("async_valid", 16'h0000);        check(16'(o_Vector_Valid));
        expect_val("async_vector", 16'h0000);       check(o_Vector);
        expect_val("async_interrupts", 16'h0000);   check(16'(o_Interrupts));
        i_Bus_In = 1'b1;
        #1;
        expect_val("async_o_bus", 16'h0000);        check(16'(o_Bus));
        i_Bus_In = 1'b0;
        i_Handle_Interrupt = 1'b0;
        tick();
        i_Rst_n = 1'b1;

        // Request high across reset release gives one edge.
        tick();
        read_reg(16'hFF0F, rd);
        expect_val("post_reset_edge", 16'h00E1);    check(16'(rd));
        read_reg(16'hFFFF, rd);
        expect_val("post_reset_ie", 16'h0000);      check(16'(rd));
        i_Handle_Interrupt = 1'b1;
        tick();
        expect_val("post_reset_idle_vec", 16'h0000); check(o_Vector);
        expect_val("post_reset_idle_val", 16'h0001); check(16'(o_Vector_Valid));
        i_Handle_Interrupt = 1'b0;
        tick();
        expect_val("post_reset_release", 16'h0000); check(16'(o_Vector_Valid));

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 i_Clk  in  1  system clock; all state updates on rising edge.
REQ-003 i_Rst_n  in  1  asynchronous active-low reset.
REQ-004 i_Enable  in  1  clock enable; no state changes while low, except reset.
REQ-005 i_Address  in  16  CPU memory address.
REQ-006 i_Address_Out  in  1  CPU is presenting a target address.
REQ-007 i_Bus  in  8  data written by the CPU.
REQ-008 i_Bus_Out  in  1  CPU write strobe.
REQ-009 i_Bus_In  in  1  CPU read strobe.
REQ-010 i_Handle_Interrupt  in  1  CPU is dispatching an interrupt.
REQ-011 i_Requests  in  5  peripheral request lines: bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad.
REQ-012 o_Bus  out  8  read data; 8'h00 when not selected, so the CPU can OR it onto its bus.
REQ-013 o_Interrupts  out  5  pending-and-enabled flags to the CPU; lower bit has priority.
REQ-014 o_Vector  out  16  dispatch target address.
REQ-015 o_Vector_Valid  out  1  o_Vector is valid.

Function
REQ-016 On i_Enable high with i_Address_Out high, SHALL latch i_Address into an internal address register.
REQ-017 Register map, decoded from the latched address:
- IF at 16'hFF0F, 5 bits.
- IE at 16'hFFFF, 8 bits.
- All other addresses unselected.
REQ-018 Read, combinational while i_Bus_In is high:
- IF selected: o_Bus = {3'b111, IF}.
- IE selected: o_Bus = IE.
- Otherwise: o_Bus = 8'h00.
REQ-019 Write: with i_Bus_Out and i_Enable high, the selected register SHALL load i_Bus at the next edge; IF takes bits [4:0].
REQ-020 Request capture: each i_Requests bit SHALL be rising-edge detected against its previous enabled-cycle value; a detected edge sets the matching IF bit.
REQ-021 o_Interrupts SHALL equal IF & IE[4:0], combinationally.
REQ-022 IF next-value precedence, lowest to highest:
- CPU write value.
- Acknowledge clear.
- Peripheral edge set (edge wins over both write and clear).
REQ-023 Acknowledge FSM states: IDLE and SERVING.
REQ-024 IDLE -> SERVING on i_Enable & i_Handle_Interrupt. In that same edge:
- n = lowest set bit of o_Interrupts.
- IF[n] cleared.
- o_Vector = 16'h0040 + 8*n.
- o_Vector_Valid = 1.
REQ-025 If o_Interrupts is zero at that edge (cancelled dispatch):
- o_Vector = 16'h0000.
- o_Vector_Valid = 1.
- No IF change.
REQ-026 In SERVING, o_Vector and o_Vector_Valid SHALL hold, and further acknowledges SHALL be ignored.
REQ-027 SERVING -> IDLE when i_Handle_Interrupt is low with i_Enable high; o_Vector_Valid deasserts at that edge, and o_Vector holds its last value.
REQ-028 Request edges SHALL keep being captured in every state.
REQ-029 IE SHALL NOT gate capture: flags set while disabled remain pending.

Reset
REQ-030 While i_Rst_n is low, SHALL asynchronously force to zero:
- IF and IE.
- Address latch.
- Edge-history register.
- o_Vector and o_Vector_Valid.
- FSM state to IDLE.
REQ-031 o_Bus and o_Interrupts SHALL read 0 during reset.
REQ-032 Requests high at reset release SHALL produce one edge on the first enabled cycle.
REQ-033 Reset mid-SERVING SHALL return to IDLE, with no pending vector retained.

Structure
REQ-034 Shared package SHALL hold:
- IF address 16'hFF0F and IE address 16'hFFFF.
- Vector base 16'h0040 and vector stride 8.
- Source count 5.
- FSM state encoding.
REQ-035 SHALL contain one sub-module, edge_detect, parameterized by width; it holds the history register and takes clock, reset and enable.

Verification
REQ-036 Timer requests: IE=8'h04 via write to FFFF; pulse i_Requests[2] -> next edge IF=5'h04, o_Interrupts=5'h04, read FF0F returns 8'hE4.
REQ-037 Priority: IF=5'h06, IE=8'h1F, assert i_Handle_Interrupt -> o_Vector=16'h0048, o_Vector_Valid=1, IF=5'h04; drop handle -> valid=0.
REQ-038 Precedence: same edge writes IF=8'h00 and raises i_Requests[0] -> IF=5'h01.
REQ-039 Cancelled dispatch: o_Interrupts=0, assert handle -> o_Vector=16'h0000, valid=1, IF unchanged.
REQ-040 Enable gating: i_Enable=0 during a request edge and a write -> no register change; held-high request seen once enable returns.
REQ-041 Reset: reset asserted in SERVING with IF=5'h1F -> all registers 0, o_Vector_Valid=0 immediately, without waiting for a clock edge.
